// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path
//
// Datapath for a Mini SRC style 32-bit processor. Every register shares one
// 32-bit bus. A control unit, or a bench acting as one, sequences the
// datapath cycle by cycle. The datapath has no state machine of its own.
//
// Ports
//   clk, clr          rising-edge clock; synchronous active-high clear
//   alu_control       ALU operation select (A = Y, B = bus)
//   Mdatain           read data from the external memory
//   R0out..Yout       bus source selects
//   *en               register load enables
//   Read              MDR input select (1 = Mdatain, 0 = bus)
//   Write             memory write strobe, used only by the external memory
//   Gra/Grb/Grc       pick the IR register field Ra / Rb / Rc
//   BAout, Rin, Rout  drive or load the register picked by Gra/Grb/Grc
//   ConIn             load the branch condition flip-flop
//   BusMuxOut         current bus value
//   MARq, MDRq, IRq   memory address, memory write data, instruction
//   CON               branch condition
// -----------------------------------------------------------------------------
module data_path (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  alu_control,
  input  logic [31:0] Mdatain,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        MDROut,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHIout,
  input  logic        ZLOout,
  input  logic        Pout,
  input  logic        Cout,
  input  logic        Yout,
  input  logic        IRen,
  input  logic        MARen,
  input  logic        MDRen,
  input  logic        Read,
  input  logic        Write,
  input  logic        Yen,
  input  logic        Pen,
  input  logic        ZHIen,
  input  logic        ZLOen,
  input  logic        HIen,
  input  logic        LOen,
  input  logic        R0en,
  input  logic        R1en,
  input  logic        R2en,
  input  logic        R3en,
  input  logic        R4en,
  input  logic        R5en,
  input  logic        R6en,
  input  logic        R7en,
  input  logic        R8en,
  input  logic        R9en,
  input  logic        R10en,
  input  logic        R11en,
  input  logic        R12en,
  input  logic        R13en,
  input  logic        R14en,
  input  logic        R15en,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        BAout,
  input  logic        ConIn,
  input  logic        Rin,
  input  logic        Rout,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MARq,
  output logic [31:0] MDRq,
  output logic [31:0] IRq,
  output logic        CON
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_INC  = 5'b01101;

  logic [31:0] regFile_q [16];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q;
  logic [63:0] z_q;
  logic        con_q;

  logic [15:0] rOutVec, rEnVec, sel, rLoad, rDrive;
  logic [3:0]  field;
  logic        anySel;
  logic [31:0] cSext, busValue, mdr_d;
  logic [63:0] z_d;
  logic        con_d;
  logic        unusedWrite;

  assign unusedWrite = Write;

  assign rOutVec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign rEnVec  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                    R7en, R6en, R5en, R4en, R3en, R2en, R1en, R0en};

  // Select-and-encode: pick one IR register field (Gra over Grb over Grc)
  // and decode it to a one-hot register select. No field picked means no
  // register is selected.
  always_comb begin
    field  = 4'd0;
    anySel = 1'b0;
    if (Gra) begin
      field  = ir_q[26:23];
      anySel = 1'b1;
    end else if (Grb) begin
      field  = ir_q[22:19];
      anySel = 1'b1;
    end else if (Grc) begin
      field  = ir_q[18:15];
      anySel = 1'b1;
    end
    sel = anySel ? (16'd1 << field) : 16'd0;
  end

  // Effective per-register load and drive strobes merge the explicit
  // enables with the IR-field selected register.
  assign rLoad  = rEnVec  | ({16{Rin}} & sel);
  assign rDrive = rOutVec | ({16{Rout | BAout}} & sel);
  assign cSext  = {{13{ir_q[18]}}, ir_q[18:0]};

  // Bus multiplexer. Sources are applied lowest priority first so the last
  // match wins; R0 ends up with the highest priority. A base-address drive
  // of R0 means "no base", so the bus reads zero in that case.
  always_comb begin
    busValue = 32'd0;
    if (Yout)   busValue = y_q;
    if (Cout)   busValue = cSext;
    if (MDROut) busValue = mdr_q;
    if (Pout)   busValue = pc_q;
    if (ZLOout) busValue = z_q[31:0];
    if (ZHIout) busValue = z_q[63:32];
    if (LOout)  busValue = lo_q;
    if (HIout)  busValue = hi_q;
    for (int k = 15; k >= 0; k--) begin
      if (rDrive[k]) busValue = regFile_q[k];
    end
    if (BAout && sel[0]) busValue = 32'd0;
  end

  assign mdr_d = Read ? Mdatain : busValue;

  // ALU: A is Y, B is the bus. Only MUL and DIV produce a high word.
  // The most-negative / -1 division is handled explicitly because its true
  // quotient does not fit in 32 bits.
  logic signed [31:0] aS, bS;
  logic [63:0]        aExt, bExt, rot;
  logic [4:0]         shamt;

  assign aS    = y_q;
  assign bS    = busValue;
  assign aExt  = {{32{y_q[31]}}, y_q};
  assign bExt  = {{32{busValue[31]}}, busValue};
  assign shamt = busValue[4:0];

  always_comb begin
    z_d = 64'd0;
    rot = 64'd0;
    case (alu_control)
      OP_ADD:  z_d = {32'd0, y_q + busValue};
      OP_SUB:  z_d = {32'd0, y_q - busValue};
      OP_AND:  z_d = {32'd0, y_q & busValue};
      OP_OR:   z_d = {32'd0, y_q | busValue};
      OP_SHR:  z_d = {32'd0, y_q >> shamt};
      OP_SHRA: z_d = {32'd0, 32'(aS >>> shamt)};
      OP_SHL:  z_d = {32'd0, y_q << shamt};
      OP_ROR: begin
        rot = {y_q, y_q} >> shamt;
        z_d = {32'd0, rot[31:0]};
      end
      OP_ROL: begin
        rot = {y_q, y_q} << shamt;
        z_d = {32'd0, rot[63:32]};
      end
      OP_MUL:  z_d = aExt * bExt;
      OP_DIV: begin
        if (busValue == 32'd0) begin
          z_d = {y_q, 32'hFFFF_FFFF};
        end else if (y_q == 32'h8000_0000 && busValue == 32'hFFFF_FFFF) begin
          z_d = {32'd0, 32'h8000_0000};
        end else begin
          z_d = {32'(aS % bS), 32'(aS / bS)};
        end
      end
      OP_NEG:  z_d = {32'd0, 32'd0 - busValue};
      OP_NOT:  z_d = {32'd0, ~busValue};
      OP_INC:  z_d = {32'd0, busValue + 32'd1};
      default: z_d = 64'd0;
    endcase
  end

  // Branch condition evaluated on the bus, chosen by IR[20:19].
  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (busValue == 32'd0);
      2'b01: con_d = (busValue != 32'd0);
      2'b10: con_d = ~busValue[31];
      2'b11: con_d = busValue[31];
      default: con_d = 1'b0;
    endcase
  end

  // All architectural registers. Clear wins over every enable; each
  // register otherwise loads its input on its enable and holds.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 16; k++) regFile_q[k] <= 32'd0;
      pc_q  <= 32'd0;
      ir_q  <= 32'd0;
      mar_q <= 32'd0;
      mdr_q <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      y_q   <= 32'd0;
      z_q   <= 64'd0;
      con_q <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (rLoad[k]) regFile_q[k] <= busValue;
      end
      if (Pen)   pc_q  <= busValue;
      if (IRen)  ir_q  <= busValue;
      if (MARen) mar_q <= busValue;
      if (MDRen) mdr_q <= mdr_d;
      if (HIen)  hi_q  <= busValue;
      if (LOen)  lo_q  <= busValue;
      if (Yen)   y_q   <= busValue;
      if (ZHIen) z_q[63:32] <= z_d[63:32];
      if (ZLOen) z_q[31:0]  <= z_d[31:0];
      if (ConIn) con_q <= con_d;
    end
  end

  assign BusMuxOut = busValue;
  assign MARq      = mar_q;
  assign MDRq      = mdr_q;
  assign IRq       = ir_q;
  assign CON       = con_q;

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path
//
// Bench for data_path. The bench acts as the control unit and keeps its own
// model of the register contents. ALU results come from a table of known
// answers and from random operands checked against a bit-level model.
// -----------------------------------------------------------------------------
module tb_data_path;

  localparam int D_HI  = 16;
  localparam int D_LO  = 17;
  localparam int D_PC  = 18;
  localparam int D_Y   = 19;
  localparam int D_IR  = 20;
  localparam int D_MAR = 21;
  localparam int S_ZHI = 22;
  localparam int S_ZLO = 23;
  localparam int S_MDR = 24;
  localparam int S_C   = 25;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  aluControl;
  logic [31:0] mdatain;
  logic [15:0] rOut, rEn;
  logic mdrOut, hiOut, loOut, zhiOut, zloOut, pOut, cOut, yOut;
  logic irEn, marEn, mdrEn, read, write, yEn, pEn, zhiEn, zloEn, hiEn, loEn;
  logic gra, grb, grc, baOut, conIn, rIn, rOutG;
  logic [31:0] bus, marQ, mdrQ, irQ;
  logic        con;

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] mR [16];
  logic [31:0] mPc, mIr, mMar, mMdr, mHi, mLo, mY;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    string       name;
  } aluVec_t;

  aluVec_t vecs[$];

  always #5 clk = ~clk;

  data_path dut (
    .clk(clk), .clr(clr), .alu_control(aluControl), .Mdatain(mdatain),
    .R0out(rOut[0]), .R1out(rOut[1]), .R2out(rOut[2]), .R3out(rOut[3]),
    .R4out(rOut[4]), .R5out(rOut[5]), .R6out(rOut[6]), .R7out(rOut[7]),
    .R8out(rOut[8]), .R9out(rOut[9]), .R10out(rOut[10]), .R11out(rOut[11]),
    .R12out(rOut[12]), .R13out(rOut[13]), .R14out(rOut[14]), .R15out(rOut[15]),
    .MDROut(mdrOut), .HIout(hiOut), .LOout(loOut), .ZHIout(zhiOut),
    .ZLOout(zloOut), .Pout(pOut), .Cout(cOut), .Yout(yOut),
    .IRen(irEn), .MARen(marEn), .MDRen(mdrEn), .Read(read), .Write(write),
    .Yen(yEn), .Pen(pEn), .ZHIen(zhiEn), .ZLOen(zloEn), .HIen(hiEn), .LOen(loEn),
    .R0en(rEn[0]), .R1en(rEn[1]), .R2en(rEn[2]), .R3en(rEn[3]),
    .R4en(rEn[4]), .R5en(rEn[5]), .R6en(rEn[6]), .R7en(rEn[7]),
    .R8en(rEn[8]), .R9en(rEn[9]), .R10en(rEn[10]), .R11en(rEn[11]),
    .R12en(rEn[12]), .R13en(rEn[13]), .R14en(rEn[14]), .R15en(rEn[15]),
    .Gra(gra), .Grb(grb), .Grc(grc), .BAout(baOut), .ConIn(conIn),
    .Rin(rIn), .Rout(rOutG),
    .BusMuxOut(bus), .MARq(marQ), .MDRq(mdrQ), .IRq(irQ), .CON(con)
  );

  // Behavioural ALU: shifts and rotates are built bit by bit from the
  // definition, MUL/DIV use plain signed integer arithmetic.
  function automatic logic [63:0] aluModel(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] lo, hi;
    logic [4:0]  idx;
    logic        bitV;
    int          s, ia, ib, src;
    longint      p;
    lo = 32'd0;
    hi = 32'd0;
    s  = int'(b[4:0]);
    ia = a;
    ib = b;
    case (op)
      5'd0:  lo = a + b;
      5'd1:  lo = a - b;
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
        for (int i = 31; i >= 0; i--) begin
          bitV = 1'b0;
          case (op)
            5'd4, 5'd5: begin
              src = i + s;
              idx = 5'(src % 32);
              if (src < 32) bitV = a[idx];
              else bitV = (op == 5'd5) ? a[31] : 1'b0;
            end
            5'd6: begin
              src = i - s;
              idx = 5'((src + 32) % 32);
              bitV = (src >= 0) ? a[idx] : 1'b0;
            end
            5'd7: begin
              idx = 5'((i + s) % 32);
              bitV = a[idx];
            end
            default: begin
              idx = 5'((i - s + 32) % 32);
              bitV = a[idx];
            end
          endcase
          lo = {lo[30:0], bitV};
        end
      end
      5'd9: begin
        p = longint'(ia) * longint'(ib);
        {hi, lo} = p;
      end
      5'd10: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = 32'(ia / ib);
          hi = 32'(ia % ib);
        end
      end
      5'd11: lo = 32'd0 - b;
      5'd12: lo = ~b;
      5'd13: lo = b + 32'd1;
      default: lo = 32'd0;
    endcase
    return {hi, lo};
  endfunction

  function automatic logic [31:0] cModel(input logic [31:0] ir);
    int v;
    v = int'(ir[18:0]);
    if (v >= (1 << 18)) v = v - (1 << 19);
    return 32'(v);
  endfunction

  function automatic logic conModel(input logic [1:0] c, input logic [31:0] v);
    int sv;
    sv = v;
    case (c)
      2'd0: return v == 32'd0;
      2'd1: return v != 32'd0;
      2'd2: return sv >= 0;
      default: return sv < 0;
    endcase
  endfunction

  function automatic aluVec_t mkVec(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] expLo,
                                    input logic [31:0] expHi, input string name);
    aluVec_t v;
    v.op = op; v.a = a; v.b = b; v.expLo = expLo; v.expHi = expHi; v.name = name;
    return v;
  endfunction

  task automatic clearControls();
    aluControl = 5'd0; mdatain = 32'd0; rOut = 16'd0; rEn = 16'd0;
    mdrOut = 0; hiOut = 0; loOut = 0; zhiOut = 0; zloOut = 0; pOut = 0; cOut = 0; yOut = 0;
    irEn = 0; marEn = 0; mdrEn = 0; read = 0; write = 0; yEn = 0; pEn = 0;
    zhiEn = 0; zloEn = 0; hiEn = 0; loEn = 0;
    gra = 0; grb = 0; grc = 0; baOut = 0; conIn = 0; rIn = 0; rOutG = 0;
  endtask

  // One clock edge with the currently driven controls, then idle controls.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic driveSrc(input int src);
    if (src < 16) rOut[src] = 1'b1;
    else case (src)
      D_HI:  hiOut  = 1'b1;
      D_LO:  loOut  = 1'b1;
      D_PC:  pOut   = 1'b1;
      D_Y:   yOut   = 1'b1;
      S_ZHI: zhiOut = 1'b1;
      S_ZLO: zloOut = 1'b1;
      S_MDR: mdrOut = 1'b1;
      default: cOut = 1'b1;
    endcase
  endtask

  task automatic setEnable(input int dst);
    if (dst < 16) rEn[dst] = 1'b1;
    else case (dst)
      D_HI:  hiEn  = 1'b1;
      D_LO:  loEn  = 1'b1;
      D_PC:  pEn   = 1'b1;
      D_Y:   yEn   = 1'b1;
      D_IR:  irEn  = 1'b1;
      default: marEn = 1'b1;
    endcase
  endtask

  task automatic checkSrc(input string name, input int src, input logic [31:0] exp);
    logic [31:0] v;
    clearControls();
    driveSrc(src);
    #1;
    v = bus;
    clearControls();
    #1;
    checkOutput(name, v, exp);
  endtask

  task automatic putMdr(input logic [31:0] v);
    mdatain = v; read = 1'b1; mdrEn = 1'b1;
    applyStimulus();
    mMdr = v;
  endtask

  task automatic loadReg(input int dst, input logic [31:0] v);
    putMdr(v);
    mdrOut = 1'b1;
    setEnable(dst);
    applyStimulus();
    if (dst < 16) mR[dst] = v;
    else case (dst)
      D_HI:  mHi  = v;
      D_LO:  mLo  = v;
      D_PC:  mPc  = v;
      D_Y:   mY   = v;
      D_IR:  mIr  = v;
      default: mMar = v;
    endcase
  endtask

  task automatic runAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    loadReg(D_Y, a);
    putMdr(b);
    mdrOut = 1'b1; aluControl = op; zhiEn = 1'b1; zloEn = 1'b1;
    applyStimulus();
  endtask

  task automatic resetModel();
    for (int k = 0; k < 16; k++) mR[k] = 32'd0;
    mPc = 0; mIr = 0; mMar = 0; mMdr = 0; mHi = 0; mLo = 0; mY = 0;
  endtask

  initial begin
    logic [63:0] exp64;
    logic [31:0] a, b, irVal;
    logic [4:0]  op;
    int          k, j;

    vecs.push_back(mkVec(5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h0,        "ADD wrap"));
    vecs.push_back(mkVec(5'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 32'h0,        "SUB wrap"));
    vecs.push_back(mkVec(5'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0,        "AND"));
    vecs.push_back(mkVec(5'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'h0,        "OR"));
    vecs.push_back(mkVec(5'd4,  32'h80000001, 32'd1,        32'h40000000, 32'h0,        "SHR"));
    vecs.push_back(mkVec(5'd5,  32'h80000001, 32'd1,        32'hC0000000, 32'h0,        "SHRA"));
    vecs.push_back(mkVec(5'd6,  32'h00000001, 32'h21,       32'h00000002, 32'h0,        "SHL uses B[4:0]"));
    vecs.push_back(mkVec(5'd7,  32'h80000001, 32'd1,        32'hC0000000, 32'h0,        "ROR"));
    vecs.push_back(mkVec(5'd7,  32'h12345678, 32'd0,        32'h12345678, 32'h0,        "ROR by 0"));
    vecs.push_back(mkVec(5'd8,  32'h80000001, 32'd1,        32'h00000003, 32'h0,        "ROL"));
    vecs.push_back(mkVec(5'd9,  32'hFFFFFFFA, 32'd4,        32'hFFFFFFE8, 32'hFFFFFFFF, "MUL neg"));
    vecs.push_back(mkVec(5'd9,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, "MUL carry"));
    vecs.push_back(mkVec(5'd10, 32'd7,        32'd2,        32'h00000003, 32'h00000001, "DIV"));
    vecs.push_back(mkVec(5'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, "DIV neg"));
    vecs.push_back(mkVec(5'd10, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, "DIV by 0"));
    vecs.push_back(mkVec(5'd11, 32'd9,        32'd1,        32'hFFFFFFFF, 32'h0,        "NEG"));
    vecs.push_back(mkVec(5'd12, 32'd9,        32'd0,        32'hFFFFFFFF, 32'h0,        "NOT"));
    vecs.push_back(mkVec(5'd13, 32'd9,        32'hFFFFFFFF, 32'h00000000, 32'h0,        "INC wrap"));
    vecs.push_back(mkVec(5'd14, 32'd5,        32'd5,        32'h00000000, 32'h0,        "undefined op"));

    clearControls();
    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;

    // Fill every register with non-zero data, then clear with all enables up.
    putMdr(32'hA5A5A5A5);
    mdrOut = 1; rEn = 16'hFFFF; hiEn = 1; loEn = 1; yEn = 1; pEn = 1; irEn = 1; marEn = 1;
    zhiEn = 1; zloEn = 1;
    applyStimulus();
    mdrOut = 1; aluControl = 5'd9; zhiEn = 1; zloEn = 1;
    applyStimulus();
    conIn = 1;
    applyStimulus();
    clr = 1; rEn = 16'hFFFF; hiEn = 1; loEn = 1; yEn = 1; pEn = 1; irEn = 1; marEn = 1;
    zhiEn = 1; zloEn = 1; conIn = 1; read = 1; mdrEn = 1; mdatain = 32'hFFFFFFFF; mdrOut = 1;
    applyStimulus();
    clr = 0;
    resetModel();
    for (int r = 0; r < 16; r++) checkSrc("reset R", r, 32'd0);
    checkSrc("reset HI", D_HI, 32'd0);
    checkSrc("reset LO", D_LO, 32'd0);
    checkSrc("reset ZHI", S_ZHI, 32'd0);
    checkSrc("reset ZLO", S_ZLO, 32'd0);
    checkSrc("reset PC", D_PC, 32'd0);
    checkSrc("reset MDR bus", S_MDR, 32'd0);
    checkSrc("reset Y", D_Y, 32'd0);
    checkSrc("reset C", S_C, 32'd0);
    checkOutput("reset MARq", marQ, 32'd0);
    checkOutput("reset MDRq", mdrQ, 32'd0);
    checkOutput("reset IRq", irQ, 32'd0);
    checkOutput("reset CON", {31'd0, con}, 32'd0);
    checkOutput("idle bus", bus, 32'd0);

    // Random register file traffic.
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(0, 15);
      loadReg(k, $urandom);
      j = $urandom_range(0, 15);
      checkSrc("rand reg", j, mR[j]);
      checkSrc("rand reg written", k, mR[k]);
    end

    // Bus priority, self transfer and the MDR bus-side input.
    loadReg(0, 32'd11);
    loadReg(1, 32'd22);
    loadReg(D_HI, 32'd33);
    loadReg(D_Y, 32'd44);
    rOut[0] = 1; rOut[1] = 1; #1;
    checkOutput("prio R0 over R1", bus, 32'd11);
    clearControls();
    hiOut = 1; yOut = 1; #1;
    checkOutput("prio HI over Y", bus, 32'd33);
    clearControls();
    rOut[15] = 1; hiOut = 1; #1;
    checkOutput("prio R15 over HI", bus, mR[15]);
    clearControls();
    rOut[4] = 1; rEn[4] = 1;
    applyStimulus();
    checkSrc("self transfer R4", 4, mR[4]);
    yOut = 1; mdrEn = 1;
    applyStimulus();
    mMdr = mY;
    checkOutput("MDR from bus", mdrQ, 32'd44);

    // Fetch and jump.
    loadReg(2, 32'h40);
    loadReg(D_PC, 32'd5);
    pOut = 1; marEn = 1;
    applyStimulus();
    checkOutput("T0 MARq", marQ, 32'd5);
    read = 1; mdrEn = 1; mdatain = 32'h01000000;
    applyStimulus();
    checkOutput("T1 MDRq", mdrQ, 32'h01000000);
    mdrOut = 1; irEn = 1;
    applyStimulus();
    mIr = 32'h01000000;
    checkOutput("T2 IRq", irQ, 32'h01000000);
    gra = 1; rOutG = 1; #1;
    checkOutput("T3 bus Ra", bus, 32'h40);
    pEn = 1;
    applyStimulus();
    checkSrc("jump PC", D_PC, 32'h40);

    // Select/encode with base-address drive (IR Rb field is 0 here).
    loadReg(0, 32'd7);
    grb = 1; baOut = 1; #1;
    checkOutput("BAout R0 reads 0", bus, 32'd0);
    clearControls();
    grb = 1; rOutG = 1; #1;
    checkOutput("Rout R0", bus, 32'd7);
    clearControls();
    loadReg(3, 32'h333);
    loadReg(5, 32'h555);
    loadReg(9, 32'h999);
    irVal = (32'd3 << 23) | (32'd5 << 19) | (32'd9 << 15);
    loadReg(D_IR, irVal);
    gra = 1; grb = 1; rOutG = 1; #1;
    checkOutput("Gra wins", bus, 32'h333);
    clearControls();
    grb = 1; grc = 1; rOutG = 1; #1;
    checkOutput("Grb over Grc", bus, 32'h555);
    clearControls();
    grc = 1; rOutG = 1; #1;
    checkOutput("Grc", bus, 32'h999);
    clearControls();
    grb = 1; baOut = 1; #1;
    checkOutput("BAout nonzero reg", bus, 32'h555);
    clearControls();
    rOutG = 1; #1;
    checkOutput("no field selected", bus, 32'd0);
    clearControls();
    checkSrc("C sext", S_C, cModel(irVal));
    putMdr(32'h0000CAFE);
    mdrOut = 1; grc = 1; rIn = 1;
    applyStimulus();
    mR[9] = 32'h0000CAFE;
    checkSrc("Rin via Grc", 9, mR[9]);
    checkSrc("Rin left R5", 5, mR[5]);

    // Known-answer ALU table.
    foreach (vecs[i]) begin
      runAlu(vecs[i].op, vecs[i].a, vecs[i].b);
      checkSrc({vecs[i].name, " lo"}, S_ZLO, vecs[i].expLo);
      checkSrc({vecs[i].name, " hi"}, S_ZHI, vecs[i].expHi);
    end

    // Independent ZHI/ZLO enables: only the low half follows a new ADD.
    runAlu(5'd9, 32'hFFFFFFFA, 32'd4);
    loadReg(D_Y, 32'd1);
    putMdr(32'd2);
    mdrOut = 1; aluControl = 5'd0; zloEn = 1;
    applyStimulus();
    checkSrc("ZLO alone lo", S_ZLO, 32'd3);
    checkSrc("ZLO alone hi kept", S_ZHI, 32'hFFFFFFFF);

    // Random ALU operations against the model.
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = (n % 7 == 0) ? 32'd0 : $urandom;
      if (op == 5'd10 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      runAlu(op, a, b);
      exp64 = aluModel(op, a, b);
      checkSrc("rand ALU lo", S_ZLO, exp64[31:0]);
      checkSrc("rand ALU hi", S_ZHI, exp64[63:32]);
    end

    // Branch condition.
    loadReg(D_IR, 32'h00180000);
    putMdr(32'h80000000);
    mdrOut = 1; conIn = 1;
    applyStimulus();
    checkOutput("CON negative", {31'd0, con}, 32'd1);
    loadReg(D_IR, 32'h0);
    putMdr(32'd5);
    mdrOut = 1; conIn = 1;
    applyStimulus();
    checkOutput("CON zero test false", {31'd0, con}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < 3; v++) begin
        a = (v == 0) ? 32'd0 : (v == 1) ? 32'd5 : 32'h80000000;
        loadReg(D_IR, 32'(c) << 19);
        putMdr(a);
        mdrOut = 1; conIn = 1;
        applyStimulus();
        checkOutput("CON cond", {31'd0, con}, {31'd0, conModel(2'(c), a)});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
